irig_b_encoder: RTL and testbench

IRIG_B_ENCODER -- requirements
Module: irig_b_encoder

---
 rtl/irig_b_pkg.sv | 47 ++++
 rtl/irig_b_time_cnt.sv | 99 +++++++++
 rtl/irig_b_encoder.sv | 110 +++++++++++
 tb/tb_irig_b_encoder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irig_b_pkg.sv
// rtl/irig_b_pkg.sv - IRIG-B encoder shared types, default timing, marker map and field bit map
package irig_b_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_SYM_LEN  = 1250000;
    localparam int unsigned DEF_P_LEN    = 1000000;
    localparam int unsigned DEF_ONE_LEN  = 625000;
    localparam int unsigned DEF_ZERO_LEN = 250000;

    typedef struct packed {
        logic [6:0] sec;
        logic [6:0] min;
        logic [5:0] hour;
        logic [9:0] day;
        logic [7:0] year;
    } time_t;

    localparam time_t TIME_RESET = '{sec: 7'h00, min: 7'h00, hour: 6'h00, day: 10'h001, year: 8'h00};

    // Reference marker Pr at 0, then P1..P9 and the closing P0 at 99.
    localparam logic [99:0] MARKER_MASK =
        (100'd1 << 0)  | (100'd1 << 9)  | (100'd1 << 19) | (100'd1 << 29) |
        (100'd1 << 39) | (100'd1 << 49) | (100'd1 << 59) | (100'd1 << 69) |
        (100'd1 << 79) | (100'd1 << 89) | (100'd1 << 99);

    function automatic logic [99:0] frame_bits(input time_t t);
        logic [99:0] f;
        f        = '0;
        f[4:1]   = t.sec[3:0];
        f[8:6]   = t.sec[6:4];
        f[13:10] = t.min[3:0];
        f[17:15] = t.min[6:4];
        f[23:20] = t.hour[3:0];
        f[26:25] = t.hour[5:4];
        f[33:30] = t.day[3:0];
        f[38:35] = t.day[7:4];
        f[41:40] = t.day[9:8];
        f[53:50] = t.year[3:0];
        f[58:55] = t.year[7:4];
        return f;
    endfunction

endpackage

// File: rtl/irig_b_time_cnt.sv
// rtl/irig_b_time_cnt.sv - BCD time-of-year register with load validation and 1 s frame-end rollover
module irig_b_time_cnt
    import irig_b_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       load,
    input  logic [6:0] second_in,
    input  logic [6:0] minute_in,
    input  logic [5:0] hour_in,
    input  logic [9:0] day_in,
    input  logic [7:0] year_in,
    input  logic       frame_capture,
    input  logic       frame_end,
    output time_t      time_q,
    output logic       load_err
);

    time_t      nxt;
    logic       load_ok;
    logic       pending;
    logic       leap;
    logic [9:0] day_max;
    logic       c_min, c_hour, c_day, c_year;

    always_comb begin
        load_ok = 1'b1;
        if (second_in[3:0] > 4'd9 || second_in[6:4] > 3'd5) load_ok = 1'b0;
        if (minute_in[3:0] > 4'd9 || minute_in[6:4] > 3'd5) load_ok = 1'b0;
        if (hour_in[3:0] > 4'd9 || hour_in > 6'h23) load_ok = 1'b0;
        if (day_in[3:0] > 4'd9 || day_in[7:4] > 4'd9 || day_in > 10'h366 || day_in == 10'h000) load_ok = 1'b0;
        if (year_in[3:0] > 4'd9 || year_in[7:4] > 4'd9) load_ok = 1'b0;
    end

    // 10*t+u is a multiple of 4 when t is even and u is 0/4/8, or t is odd and u is 2/6.
    assign leap    = time_q.year[4] ? (time_q.year[3:0] == 4'd2 || time_q.year[3:0] == 4'd6)
                                    : (time_q.year[3:0] == 4'd0 || time_q.year[3:0] == 4'd4 || time_q.year[3:0] == 4'd8);
    assign day_max = leap ? 10'h366 : 10'h365;

    always_comb begin
        nxt    = time_q;
        c_min  = 1'b0;
        c_hour = 1'b0;
        c_day  = 1'b0;
        c_year = 1'b0;
        if (time_q.sec == 7'h59) begin
            nxt.sec = '0;
            c_min   = 1'b1;
        end else if (time_q.sec[3:0] == 4'd9) nxt.sec = {time_q.sec[6:4] + 3'd1, 4'd0};
        else nxt.sec[3:0] = time_q.sec[3:0] + 4'd1;
        if (c_min) begin
            if (time_q.min == 7'h59) begin
                nxt.min = '0;
                c_hour  = 1'b1;
            end else if (time_q.min[3:0] == 4'd9) nxt.min = {time_q.min[6:4] + 3'd1, 4'd0};
            else nxt.min[3:0] = time_q.min[3:0] + 4'd1;
        end
        if (c_hour) begin
            if (time_q.hour == 6'h23) begin
                nxt.hour = '0;
                c_day    = 1'b1;
            end else if (time_q.hour[3:0] == 4'd9) nxt.hour = {time_q.hour[5:4] + 2'd1, 4'd0};
            else nxt.hour[3:0] = time_q.hour[3:0] + 4'd1;
        end
        // >= rather than == so a loaded 366 in a common year still wraps cleanly.
        if (c_day) begin
            if (time_q.day >= day_max) begin
                nxt.day = 10'h001;
                c_year  = 1'b1;
            end else if (time_q.day[7:0] == 8'h99) nxt.day = {time_q.day[9:8] + 2'd1, 8'h00};
            else if (time_q.day[3:0] == 4'd9) nxt.day[7:0] = {time_q.day[7:4] + 4'd1, 4'd0};
            else nxt.day[3:0] = time_q.day[3:0] + 4'd1;
        end
        if (c_year) begin
            if (time_q.year == 8'h99) nxt.year = '0;
            else if (time_q.year[3:0] == 4'd9) nxt.year = {time_q.year[7:4] + 4'd1, 4'd0};
            else nxt.year[3:0] = time_q.year[3:0] + 4'd1;
        end
    end

    // A load made after the shadow capture has not been sent yet, so it holds off the next increment.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            time_q   <= TIME_RESET;
            pending  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= load && !load_ok;
            if (load && load_ok) begin
                time_q  <= {second_in, minute_in, hour_in, day_in, year_in};
                pending <= 1'b1;
            end else begin
                if (frame_end && !pending) time_q <= nxt;
                if (frame_end || frame_capture) pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/irig_b_encoder.sv
// rtl/irig_b_encoder.sv - IRIG-B DC-level frame encoder: run FSM, symbol counters and pulse-width bit mux
module irig_b_encoder
    import irig_b_pkg::*;
#(
    parameter int unsigned SYM_LEN  = DEF_SYM_LEN,
    parameter int unsigned P_LEN    = DEF_P_LEN,
    parameter int unsigned ONE_LEN  = DEF_ONE_LEN,
    parameter int unsigned ZERO_LEN = DEF_ZERO_LEN
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       enable,
    input  logic       load,
    input  logic [6:0] second_in,
    input  logic [6:0] minute_in,
    input  logic [5:0] hour_in,
    input  logic [9:0] day_in,
    input  logic [7:0] year_in,
    output logic       irig_b,
    output logic       frame_start,
    output logic [6:0] sym_idx,
    output logic       busy,
    output logic       load_err
);

    localparam int            CW       = $clog2(SYM_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(SYM_LEN - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cyc_cnt;
    time_t         time_q, shadow;
    logic [99:0]   frame_vec;
    logic [31:0]   high_len;
    logic          sym_wrap, frame_end, frame_first, sym_bit;

    assign sym_wrap    = (cyc_cnt == CNT_LAST);
    assign frame_end   = (state == ST_RUN) && (sym_idx == 7'd99) && sym_wrap;
    assign frame_first = (state == ST_RUN) && (sym_idx == 7'd0) && (cyc_cnt == '0);
    assign busy        = (state == ST_RUN);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else state <= state_nxt;
    end

    // Enable is only sampled at frame boundaries so a frame is never cut short.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_RUN;
            ST_RUN:  if (frame_end && !enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cyc_cnt <= '0;
            sym_idx <= '0;
        end else if (state != ST_RUN) begin
            cyc_cnt <= '0;
            sym_idx <= '0;
        end else if (sym_wrap) begin
            cyc_cnt <= '0;
            sym_idx <= (sym_idx == 7'd99) ? 7'd0 : sym_idx + 7'd1;
        end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) shadow <= TIME_RESET;
        else if (frame_first) shadow <= time_q;
    end

    assign frame_vec = frame_bits(shadow);
    assign sym_bit   = frame_vec[sym_idx];

    always_comb begin
        high_len = ZERO_LEN;
        if (MARKER_MASK[sym_idx]) high_len = P_LEN;
        else if (sym_bit) high_len = ONE_LEN;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            irig_b      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            irig_b      <= busy && (32'(cyc_cnt) < high_len);
            frame_start <= frame_first;
        end
    end

    irig_b_time_cnt u_time_cnt (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .load          (load),
        .second_in     (second_in),
        .minute_in     (minute_in),
        .hour_in       (hour_in),
        .day_in        (day_in),
        .year_in       (year_in),
        .frame_capture (frame_first),
        .frame_end     (frame_end),
        .time_q        (time_q),
        .load_err      (load_err)
    );

endmodule

// File: tb/tb_irig_b_encoder.sv
// tb/tb_irig_b_encoder.sv - directed self-checking bench for irig_b_encoder
module tb_irig_b_encoder;

    localparam int SYM = 100;
    localparam int PL  = 80;
    localparam int OL  = 50;
    localparam int ZL  = 20;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       enable    = 1'b0;
    logic       load      = 1'b0;
    logic [6:0] second_in = '0;
    logic [6:0] minute_in = '0;
    logic [5:0] hour_in   = '0;
    logic [9:0] day_in    = '0;
    logic [7:0] year_in   = '0;
    logic       irig_b, frame_start, busy, load_err;
    logic [6:0] sym_idx;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hl[100];
    logic [37:0] dec_time;
    int          bad_syms;
    logic        fs_seen;
    logic [6:0]  fs_sym;

    always #5 sys_clk = ~sys_clk;

    irig_b_encoder #(.SYM_LEN(SYM), .P_LEN(PL), .ONE_LEN(OL), .ZERO_LEN(ZL)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .enable      (enable),
        .load        (load),
        .second_in   (second_in),
        .minute_in   (minute_in),
        .hour_in     (hour_in),
        .day_in      (day_in),
        .year_in     (year_in),
        .irig_b      (irig_b),
        .frame_start (frame_start),
        .sym_idx     (sym_idx),
        .busy        (busy),
        .load_err    (load_err)
    );

    task automatic do_load(input logic [37:0] t);
        {second_in, minute_in, hour_in, day_in, year_in} = t;
        load = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
    endtask

    // Measures the high time of every symbol of one frame, then decodes it.
    task automatic capture_frame(input int stop_sym);
        int          cnt;
        logic [99:0] b;
        logic        ok;
        for (int s = 0; s < 100; s++) hl[s] = 0;
        fs_seen = 1'b0;
        for (int i = 0; i < 20000 && !fs_seen; i++) begin
            @(negedge sys_clk);
            if (frame_start === 1'b1) fs_seen = 1'b1;
        end
        n_checks++;
        if (!fs_seen) begin
            n_fail++;
            $display("FAIL frame_start_timeout: frame_start=0 required 1");
        end
        fs_sym = sym_idx;
        if (fs_seen) begin
            for (int s = 0; s < 100; s++) begin
                if (s == stop_sym) enable = 1'b0;
                cnt = 0;
                for (int c = 0; c < SYM; c++) begin
                    if (s != 0 || c != 0) @(negedge sys_clk);
                    if (irig_b === 1'b1) cnt++;
                end
                hl[s] = cnt;
            end
        end else begin
            enable = 1'b0;
        end
        bad_syms = 0;
        for (int s = 0; s < 100; s++) begin
            b[s] = (hl[s] == OL);
            if (s inside {0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99}) ok = (hl[s] == PL);
            else if (s inside {[1:4], [6:8], [10:13], [15:17], [20:23], [25:26], [30:33], [35:38], [40:41], [50:53], [55:58]})
                ok = (hl[s] == OL || hl[s] == ZL);
            else ok = (hl[s] == ZL);
            if (!ok) bad_syms++;
        end
        dec_time = {b[8:6], b[4:1], b[17:15], b[13:10], b[26:25], b[23:20],
                    b[41:40], b[38:35], b[33:30], b[58:55], b[53:50]};
    endtask

    task automatic test_reset();
        int bad;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if ({irig_b, frame_start, busy, load_err, sym_idx} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {irig_b, frame_start, busy, load_err, sym_idx});
        end
        sys_rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge sys_clk);
            if (irig_b !== 1'b0 || busy !== 1'b0 || sym_idx !== 7'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_frame();
        int exp_len[5];
        exp_len = '{PL, ZL, OL, OL, ZL};
        do_load({7'h56, 7'h34, 6'h12, 10'h123, 8'h24});
        n_checks++;
        if (load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_load_err: load_err=%b required 0", load_err);
        end
        enable = 1'b1;
        capture_frame(99);
        n_checks++;
        if (fs_sym !== 7'd0) begin
            n_fail++;
            $display("FAIL frame_start_sym: sym_idx=%0d required 0", fs_sym);
        end
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (hl[s] != exp_len[s]) begin
                n_fail++;
                $display("FAIL sym%0d_high: %0d cycles required %0d", s, hl[s], exp_len[s]);
            end
        end
        n_checks++;
        if (hl[9] != PL) begin
            n_fail++;
            $display("FAIL sym9_high: %0d cycles required %0d", hl[9], PL);
        end
        n_checks++;
        if (bad_syms != 0) begin
            n_fail++;
            $display("FAIL frame1_shape: %0d bad symbols required 0", bad_syms);
        end
        n_checks++;
        if (dec_time !== {7'h56, 7'h34, 6'h12, 10'h123, 8'h24}) begin
            n_fail++;
            $display("FAIL frame1_time: %h required %h", dec_time, {7'h56, 7'h34, 6'h12, 10'h123, 8'h24});
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame1_stop_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_rollover();
        logic [37:0] ld[2];
        logic [37:0] ex[2];
        ld[0] = {7'h59, 7'h59, 6'h23, 10'h366, 8'h24};
        ex[0] = {7'h00, 7'h00, 6'h00, 10'h001, 8'h25};
        ld[1] = {7'h59, 7'h59, 6'h23, 10'h365, 8'h23};
        ex[1] = {7'h00, 7'h00, 6'h00, 10'h001, 8'h24};
        for (int k = 0; k < 2; k++) begin
            do_load(ld[k]);
            enable = 1'b1;
            capture_frame(200);
            n_checks++;
            if (dec_time !== ld[k]) begin
                n_fail++;
                $display("FAIL roll%0d_loaded: %h required %h", k, dec_time, ld[k]);
            end
            capture_frame(99);
            n_checks++;
            if (dec_time !== ex[k]) begin
                n_fail++;
                $display("FAIL roll%0d_wrapped: %h required %h", k, dec_time, ex[k]);
            end
            n_checks++;
            if (bad_syms != 0) begin
                n_fail++;
                $display("FAIL roll%0d_shape: %0d bad symbols required 0", k, bad_syms);
            end
        end
    endtask

    task automatic test_enable_drop();
        int bad;
        enable = 1'b1;
        capture_frame(40);
        n_checks++;
        if (bad_syms != 0 || hl[99] != PL) begin
            n_fail++;
            $display("FAIL drop_complete: %0d bad symbols, sym99 %0d cycles, required 0 and %0d", bad_syms, hl[99], PL);
        end
        n_checks++;
        if (dec_time !== {7'h01, 7'h00, 6'h00, 10'h001, 8'h24}) begin
            n_fail++;
            $display("FAIL drop_time: %h required %h", dec_time, {7'h01, 7'h00, 6'h00, 10'h001, 8'h24});
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_busy: busy=%b required 0", busy);
        end
        bad = 0;
        repeat (300) begin
            @(negedge sys_clk);
            if (irig_b !== 1'b0 || frame_start !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL drop_idle: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_load_err();
        logic [37:0] bad_tab[5];
        bad_tab[0] = {7'h00, 7'h6A, 6'h00, 10'h001, 8'h00};
        bad_tab[1] = {7'h00, 7'h00, 6'h24, 10'h001, 8'h00};
        bad_tab[2] = {7'h00, 7'h00, 6'h00, 10'h367, 8'h00};
        bad_tab[3] = {7'h00, 7'h00, 6'h00, 10'h000, 8'h00};
        bad_tab[4] = {7'h5A, 7'h00, 6'h00, 10'h001, 8'h9A};
        for (int k = 0; k < 5; k++) begin
            do_load(bad_tab[k]);
            n_checks++;
            if (load_err !== 1'b1) begin
                n_fail++;
                $display("FAIL load_err_pulse%0d: load_err=%b required 1", k, load_err);
            end
            @(negedge sys_clk);
            n_checks++;
            if (load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL load_err_clear%0d: load_err=%b required 0", k, load_err);
            end
        end
        enable = 1'b1;
        capture_frame(99);
        n_checks++;
        if (dec_time !== {7'h02, 7'h00, 6'h00, 10'h001, 8'h24}) begin
            n_fail++;
            $display("FAIL reject_time: %h required %h", dec_time, {7'h02, 7'h00, 6'h00, 10'h001, 8'h24});
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        found  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge sys_clk);
            if (sym_idx === 7'd25) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL sym25_timeout: sym_idx=%0d required 25", sym_idx);
        end
        repeat (10) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({irig_b, busy, frame_start, sym_idx} !== 10'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b required 0", {irig_b, busy, frame_start, sym_idx});
        end
        enable = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        enable = 1'b1;
        capture_frame(99);
        n_checks++;
        if (fs_sym !== 7'd0) begin
            n_fail++;
            $display("FAIL restart_sym: sym_idx=%0d required 0", fs_sym);
        end
        n_checks++;
        if (dec_time !== {7'h00, 7'h00, 6'h00, 10'h001, 8'h00}) begin
            n_fail++;
            $display("FAIL restart_time: %h required %h", dec_time, {7'h00, 7'h00, 6'h00, 10'h001, 8'h00});
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_rollover();
        test_enable_drop();
        test_load_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
